dac_seg_seq: RTL and testbench

DAC_SEG_SEQ -- requirements
Module: dac_seg_seq

---
 rtl/dac_seg_seq.sv | 118 +++++++++++
 tb/tb_dac_seg_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dac_seg_seq.sv
// dac_seg_seq: segmented DAC code sequencer (hold/ramp/triangle/stream) with binary LSB + thermometer MSB outputs
// Ports: clkin/rst (sync, active high); en, mode, div, code_lo, code_hi, step set the pattern;
// s_valid/s_data/s_ready stream samples in mode 3; code_out, datainbin(b), dataintherm(b) are registered
// segment outputs; sample_stb pulses after each sample; underrun is a sticky stream-starvation flag.
// Build option: define DAC_SEG_SEQ_DWA_EN for data-weighted averaging of the thermometer units.
module dac_seg_seq #(
  parameter int DATA_W = 10,
  parameter int BIN_W = 7,
  parameter int DIV_W = 16
) (
  input  logic                                clkin,
  input  logic                                rst,
  input  logic                                en,
  input  logic [1:0]                          mode,
  input  logic [DIV_W-1:0]                    div,
  input  logic [DATA_W-1:0]                   code_lo,
  input  logic [DATA_W-1:0]                   code_hi,
  input  logic [DATA_W-1:0]                   step,
  input  logic                                s_valid,
  input  logic [DATA_W-1:0]                   s_data,
  output logic                                s_ready,
  output logic [DATA_W-1:0]                   code_out,
  output logic [BIN_W-1:0]                    datainbin,
  output logic [BIN_W-1:0]                    datainbinb,
  output logic [2**(DATA_W-BIN_W)-2:0]        dataintherm,
  output logic [2**(DATA_W-BIN_W)-2:0]        datainthermb,
  output logic                                sample_stb,
  output logic                                underrun
);
  localparam int MSB_W = DATA_W - BIN_W;
  localparam int THERM_W = 2**MSB_W - 1;
  typedef enum logic {UP, DN} dir_t;
  dir_t dir, dir_n;
  logic [DIV_W-1:0] cnt;
  logic start, tick, und_set;
  logic [DATA_W-1:0] code_n;
  logic [DATA_W:0] sum, lo_step;
  logic [MSB_W-1:0] seg_cnt;
  logic [THERM_W-1:0] therm_n;
  assign tick = en && cnt == '0;
  assign s_ready = tick && mode == 2'd3;
  // one extra bit so overflow past the top code compares correctly
  assign sum = {1'b0, code_out} + {1'b0, step};
  assign lo_step = {1'b0, code_lo} + {1'b0, step};
  assign seg_cnt = code_n[DATA_W-1:BIN_W];
  always_comb begin
    code_n = code_out;
    dir_n = start ? UP : dir;
    und_set = 1'b0;
    if (start && mode != 2'd3) code_n = code_lo;
    else if (mode == 2'd0) code_n = code_lo;
    else if (mode == 2'd3) begin
      code_n = s_valid ? s_data : code_out;
      und_set = !s_valid;
    end
    else if (code_lo > code_hi) code_n = code_lo;
    else if (step == '0) code_n = code_out;
    else if (mode == 2'd1) code_n = sum > {1'b0, code_hi} ? code_lo : sum[DATA_W-1:0];
    else if (dir == UP) begin
      code_n = sum >= {1'b0, code_hi} ? code_hi : sum[DATA_W-1:0];
      dir_n = sum >= {1'b0, code_hi} ? DN : UP;
    end
    else begin
      code_n = {1'b0, code_out} <= lo_step ? code_lo : code_out - step;
      dir_n = {1'b0, code_out} <= lo_step ? UP : DN;
    end
  end
`ifdef DAC_SEG_SEQ_DWA_EN
  localparam logic [MSB_W:0] TW = (MSB_W+1)'(THERM_W);
  logic [MSB_W-1:0] ptr;
  logic [MSB_W:0] psum;
  assign psum = {1'b0, ptr} + {1'b0, seg_cnt};
  // unit k is on when its distance past the pointer (mod THERM_W) is below the count
  always_comb begin
    therm_n = '0;
    for (int k = 0; k < THERM_W; k++)
      therm_n[k] = ((k >= int'(ptr)) ? k - int'(ptr) : k + THERM_W - int'(ptr)) < int'(seg_cnt);
  end
  always_ff @(posedge clkin) begin
    if (rst) ptr <= '0;
    else if (tick) ptr <= psum >= TW ? MSB_W'(psum - TW) : MSB_W'(psum);
  end
`else
  always_comb begin
    therm_n = '0;
    for (int k = 0; k < THERM_W; k++)
      therm_n[k] = k < int'(seg_cnt);
  end
`endif
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt <= '0;
      start <= 1'b1;
      dir <= UP;
      underrun <= 1'b0;
      sample_stb <= 1'b0;
      code_out <= '0;
      datainbin <= '0;
      datainbinb <= '1;
      dataintherm <= '0;
      datainthermb <= '1;
    end
    else begin
      sample_stb <= tick;
      cnt <= !en ? '0 : tick ? div : cnt - DIV_W'(1);
      start <= !en || (start && !tick);
      underrun <= en && (underrun || (tick && und_set));
      if (tick) begin
        dir <= dir_n;
        code_out <= code_n;
        datainbin <= code_n[BIN_W-1:0];
        datainbinb <= ~code_n[BIN_W-1:0];
        dataintherm <= therm_n;
        datainthermb <= ~therm_n;
      end
    end
  end
endmodule

// File: tb/tb_dac_seg_seq.sv
// tb_dac_seg_seq: directed and random stimulus against a behavioural model of dac_seg_seq
module tb_dac_seg_seq;
  localparam int T = 7;
  logic clkin = 1'b0;
  logic rst, en, s_valid, s_ready, sample_stb, underrun;
  logic [1:0] mode;
  logic [15:0] div;
  logic [9:0] code_lo, code_hi, step, s_data, code_out;
  logic [6:0] datainbin, datainbinb, dataintherm, datainthermb;
  int total = 0, bad = 0;
  int m_cnt, m_code, m_dir, m_ptr, m_start, m_und, m_stb, m_therm;
  int exp39[5] = '{0, 4, 8, 0, 4};
  int exp40[8] = '{2, 5, 8, 9, 6, 3, 2, 5};
`ifdef DAC_SEG_SEQ_DWA_EN
  int exp42[3] = '{7, 56, 67};
`else
  int exp42[3] = '{7, 7, 7};
`endif

  always #5 clkin = ~clkin;

  dac_seg_seq dut (
    .clkin(clkin), .rst(rst), .en(en), .mode(mode), .div(div),
    .code_lo(code_lo), .code_hi(code_hi), .step(step),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .code_out(code_out), .datainbin(datainbin), .datainbinb(datainbinb),
    .dataintherm(dataintherm), .datainthermb(datainthermb),
    .sample_stb(sample_stb), .underrun(underrun)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // set of lit thermometer units for a given count, starting at unit p
  function automatic int therm_of(int c, int p);
    int r = 0;
    for (int i = 0; i < c; i++)
`ifdef DAC_SEG_SEQ_DWA_EN
      r |= 1 << ((p + i) % T);
`else
      r |= 1 << i;
`endif
    return r;
  endfunction

  task automatic model_edge();
    int lo = int'(code_lo);
    int hi = int'(code_hi);
    int st = int'(step);
    int nx = m_code;
    if (rst) begin
      m_cnt = 0; m_code = 0; m_dir = 1; m_ptr = 0;
      m_start = 1; m_und = 0; m_stb = 0; m_therm = 0;
    end
    else begin
      m_stb = (en && m_cnt == 0) ? 1 : 0;
      if (!en) begin
        m_cnt = 0; m_start = 1; m_und = 0;
      end
      else if (m_stb == 1) begin
        m_cnt = int'(div);
        if (m_start == 1) m_dir = 1;
        if (m_start == 1 && mode != 2'd3) nx = lo;
        else if (mode == 2'd0) nx = lo;
        else if (mode == 2'd3) begin
          if (s_valid) nx = int'(s_data);
          else m_und = 1;
        end
        else if (lo > hi) nx = lo;
        else if (st == 0) nx = m_code;
        else if (mode == 2'd1) nx = (m_code + st > hi) ? lo : m_code + st;
        else if (m_dir == 1) begin
          if (m_code + st >= hi) begin nx = hi; m_dir = 0; end
          else nx = m_code + st;
        end
        else if (m_code <= lo + st) begin nx = lo; m_dir = 1; end
        else nx = m_code - st;
        m_code = nx;
        m_start = 0;
        m_therm = therm_of(nx >> 7, m_ptr);
        m_ptr = (m_ptr + (nx >> 7)) % T;
      end
      else m_cnt--;
    end
  endtask

  task automatic cyc();
    #1 chk("s_ready", 32'(s_ready), (en && m_cnt == 0 && mode == 2'd3) ? 1 : 0);
    @(posedge clkin);
    model_edge();
    #1;
    chk("code_out", 32'(code_out), m_code);
    chk("bin", 32'(datainbin), m_code & 127);
    chk("binb", 32'(datainbinb), ~m_code & 127);
    chk("therm", 32'(dataintherm), m_therm);
    chk("thermb", 32'(datainthermb), ~m_therm & 127);
    chk("stb", 32'(sample_stb), m_stb);
    chk("underrun", 32'(underrun), m_und);
  endtask

  initial begin
    rst = 1; en = 0; mode = 0; div = 0; code_lo = 0; code_hi = 0; step = 0;
    s_valid = 0; s_data = 0;
    m_cnt = 0; m_code = 0; m_dir = 1; m_ptr = 0; m_start = 1; m_und = 0; m_stb = 0; m_therm = 0;
    cyc();
    cyc();
    chk("rst_binb", 32'(datainbinb), 32'h7f);
    chk("rst_thermb", 32'(datainthermb), 32'h7f);
    // hold mode, one sample every four cycles
    rst = 0; en = 1; mode = 0; div = 3; code_lo = 10'h2A5;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("hold_period", 32'(sample_stb), (i % 4 == 0) ? 1 : 0);
      if (i == 0) begin
        chk("hold_bin", 32'(datainbin), 32'h25);
        chk("hold_therm", 32'(dataintherm), 32'b0011111);
      end
    end
    // ramp with wrap to code_lo
    en = 0; cyc();
    mode = 1; code_lo = 0; code_hi = 10; step = 4; div = 0; en = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("ramp_seq", 32'(code_out), exp39[i]);
    end
    // triangle with clamping at both ends
    en = 0; cyc();
    mode = 2; code_lo = 2; code_hi = 9; step = 3; en = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("tri_seq", 32'(code_out), exp40[i]);
    end
    // stream, starved on the second tick
    en = 0; cyc();
    mode = 3; en = 1; s_valid = 1; s_data = 10'h155;
    cyc();
    chk("stream_load", 32'(code_out), 32'h155);
    s_valid = 0; s_data = 10'h0AA;
    cyc();
    chk("stream_hold", 32'(code_out), 32'h155);
    chk("stream_under", 32'(underrun), 1);
    en = 0;
    cyc();
    chk("under_clear", 32'(underrun), 0);
    // thermometer rotation (count 3 each sample)
    rst = 1; cyc();
    rst = 0; en = 1; mode = 0; div = 0; code_lo = 10'h180;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("therm_seq", 32'(dataintherm), exp42[i]);
    end
    // reset mid-ramp restarts from code_lo
    en = 0; cyc();
    mode = 1; code_lo = 4; code_hi = 20; step = 4; en = 1;
    cyc();
    cyc();
    chk("mid_ramp", 32'(code_out), 8);
    rst = 1;
    cyc();
    chk("mid_rst", 32'(code_out), 0);
    rst = 0;
    cyc();
    chk("restart", 32'(code_out), 4);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        code_lo = 10'($urandom_range(0, 400));
        code_hi = 10'($urandom_range(300, 1023));
        step = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 150));
      end
      div = 16'($urandom_range(0, 3));
      s_valid = $urandom_range(0, 3) != 0;
      s_data = 10'($urandom);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
